// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 codes, FSM states,
// and the misalignment rule used when LSU_MISALIGN_TRAP_EN is defined.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {IDLE, RMW_WR} lsu_state_t;

  // Halfword accesses need addr[0]=0, word accesses need addr[1:0]=0.
  function automatic logic misaligned(logic we, logic [2:0] f3, logic [1:0] lo);
    if (f3 == F3_W) return lo != 2'b00;
    if (f3 == F3_H || (!we && f3 == F3_HU)) return lo[0];
    return 1'b0;
  endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// CPU request/response handshake plus the word-addressed data-RAM port of the LSU.
// The LSU side uses the master modport; CPU and RAM models use the slave modport.
interface lsu_mem_port_if #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
) ();

  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [2:0]               req_funct3;
  logic [31:0]              req_addr;
  logic [DATA_WIDTH-1:0]    req_wdata;
  logic                     resp_valid;
  logic [DATA_WIDTH-1:0]    resp_rdata;
  logic                     misalign;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wd;
  logic [DATA_WIDTH-1:0]    mem_rd;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    output req_ready, resp_valid, resp_rdata, misalign, mem_we, mem_addr, mem_wd
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    input  req_ready, resp_valid, resp_rdata, misalign, mem_we, mem_addr, mem_wd
  );

endinterface

// File: rtl/lsu_align.sv
// Little-endian lane logic: extracts/extends load data from a RAM word and merges
// store bytes/halves into the old word for the read-modify-write path.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [31:0] byte_shift;
  logic [31:0] half_shift;

  assign byte_shift = word_i >> {addr_lo_i, 3'b000};
  assign half_shift = word_i >> {addr_lo_i[1], 4'b0000};

  always_comb begin
    load_data_o = '0;
    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_shift[7]}}, byte_shift[7:0]};
      F3_H:    load_data_o = {{16{half_shift[15]}}, half_shift[15:0]};
      F3_W:    load_data_o = word_i;
      F3_BU:   load_data_o = {24'h0, byte_shift[7:0]};
      F3_HU:   load_data_o = {16'h0, half_shift[15:0]};
      default: load_data_o = '0;
    endcase
  end

  always_comb begin
    merged_o = word_i;
    case (funct3_i)
      F3_B:    merged_o[{addr_lo_i, 3'b000} +: 8]      = wdata_i[7:0];
      F3_H:    merged_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: merged_o = word_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// MEM-stage load/store unit driving a word-addressed RAM without byte enables.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned LH/LHU/SH/LW/SW instead of ignoring low bits.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input logic            clk,
  input logic            rst,
  lsu_mem_port_if.master bus
);

  lsu_state_t               state_q, state_d;
  logic [DATA_WIDTH-1:0]    rmw_word_q, rmw_word_d;
  logic [ADDRESS_WIDTH-1:0] rmw_addr_q, rmw_addr_d;
  logic                     resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0]    resp_rdata_q, resp_rdata_d;
  logic                     misalign_q, misalign_d;

  logic [31:0]              load_data;
  logic [31:0]              merged;
  logic                     mis;
  logic [ADDRESS_WIDTH-1:0] req_word_addr;

  assign req_word_addr = ADDRESS_WIDTH'(bus.req_addr[31:2]);

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = misaligned(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);
`else
  assign mis = 1'b0;
`endif

  lsu_align u_align (
    .word_i      (bus.mem_rd),
    .addr_lo_i   (bus.req_addr[1:0]),
    .funct3_i    (bus.req_funct3),
    .wdata_i     (bus.req_wdata),
    .load_data_o (load_data),
    .merged_o    (merged)
  );

  always_comb begin
    state_d       = state_q;
    rmw_word_d    = rmw_word_q;
    rmw_addr_d    = rmw_addr_q;
    resp_valid_d  = 1'b0;
    resp_rdata_d  = '0;
    misalign_d    = 1'b0;
    bus.req_ready = (state_q == IDLE);
    bus.mem_we    = 1'b0;
    bus.mem_addr  = req_word_addr;
    bus.mem_wd    = bus.req_wdata;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          resp_valid_d = 1'b1;
          misalign_d   = mis;
          if (bus.req_we) begin
            case (bus.req_funct3)
              F3_W: bus.mem_we = !mis;
              F3_B, F3_H: begin
                // Sub-word stores complete from RMW_WR instead of here.
                if (!mis) begin
                  rmw_word_d   = merged;
                  rmw_addr_d   = req_word_addr;
                  resp_valid_d = 1'b0;
                  state_d      = RMW_WR;
                end
              end
              default: ;
            endcase
          end else if (!mis) begin
            resp_rdata_d = load_data;
          end
        end
      end
      RMW_WR: begin
        bus.req_ready = 1'b0;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = rmw_addr_q;
        bus.mem_wd    = rmw_word_q;
        resp_valid_d  = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (rst) bus.mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rmw_word_q   <= '0;
      rmw_addr_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rmw_word_q   <= rmw_word_d;
      rmw_addr_q   <= rmw_addr_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      misalign_q   <= misalign_d;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.misalign   = misalign_q;

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
Load/store unit for the MEM stage of the pipelined RISC-V core. It is the initiator side of the data-memory port. It accepts one CPU load/store request per handshake and drives the word-addressed data RAM (write enable, word address, write data; read data returns combinationally). The RAM has no byte enables, so SB/SH are done as a two-cycle read-modify-write. Load results are aligned, sign/zero-extended and returned one cycle after acceptance.

Parameters:
ADDRESS_WIDTH, 32, width of mem_addr (word index into data RAM)
DATA_WIDTH, 32, data width; fixed at 32, other values unsupported

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  CPU request present
req_ready  output  1  LSU can accept; high in IDLE only
req_we  input  1  1=store, 0=load
req_funct3  input  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
req_addr  input  32  byte address
req_wdata  input  32  store data (low byte/half used for SB/SH)
resp_valid  output  1  one-cycle pulse: request complete
resp_rdata  output  32  extended load data; 0 for stores
misalign  output  1  pulses with resp_valid on a misaligned access (macro only, else tied 0)
mem_we  output  1  RAM write enable
mem_addr  output  ADDRESS_WIDTH  RAM word index = req_addr[31:2], zero-extended
mem_wd  output  32  RAM write data
mem_rd  input  32  RAM read data, combinational from mem_addr

Behaviour:
- Reset values: state IDLE; resp_valid 0; resp_rdata 0; misalign 0; rmw word/addr regs 0. mem_we is forced 0 while rst=1.
- States: IDLE, RMW_WR.
- IDLE, accept = req_valid & req_ready.
  - Load: mem_addr = req_addr[31:2]. At the edge, resp_rdata <= extract(mem_rd); resp_valid <= 1 (latency 1).
  - SW: mem_we=1 and mem_wd=req_wdata combinationally in the accept cycle. At the edge, resp_valid <= 1 and resp_rdata <= 0.
  - SB/SH: mem_we=0. At the edge, capture merged = mem_rd with lane(s) replaced by req_wdata[7:0] or [15:0], capture the word address, and go to RMW_WR.
- RMW_WR: req_ready=0, mem_we=1, mem_addr=captured addr, mem_wd=merged. Next edge: resp_valid <= 1, resp_rdata <= 0, go to IDLE. SB/SH complete at T+2.
- resp_valid is 0 in every cycle without a completion. Back-to-back loads and SW sustain 1 per cycle.
- Byte lanes are little-endian:
  - byte lane = addr[1:0], bits [8*lane+7 : 8*lane]
  - half lane = addr[1]
- Extension: LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Undefined funct3 (load 011/110/111, store 011-111): accepted, no write, resp_valid pulses, resp_rdata=0.
- Reset mid-operation: rst in RMW_WR suppresses the write (mem_we=0) and returns to IDLE with no resp_valid. rst in an accept cycle drops the request.
- req_* are sampled only on accept. They are don't-care in RMW_WR.

Optional Feature:
LSU_MISALIGN_TRAP_EN.
- Defined: LH/LHU/SH with addr[0]=1, and LW/SW with addr[1:0]!=0, are misaligned.
  - No memory write; no RMW.
  - Completes in 1 cycle with resp_valid=1, misalign=1, resp_rdata=0.
- Undefined: misalign tied 0. Low address bits not needed for the lane are ignored: LH uses addr[1] only, LW/SW use addr[31:2].

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101
  - state enum lsu_state_t {IDLE, RMW_WR}
- One combinational sub-module, lsu_align: inputs word, addr[1:0], funct3. Outputs the extracted load value and the merged store word (given the old word and wdata). lsu_mem_port holds the FSM and registers.

Test Plan:
- Preload word 0x10000 = 0x8844_2211. LB 0x40003 -> resp_rdata 0xFFFFFF88 at T+1. LBU same addr -> 0x00000088. LH 0x40002 -> 0xFFFF8844. LHU same addr -> 0x00008844.
- Word 0x10000 = 0x11223344. SB wdata 0xAB to 0x40001 -> req_ready low in T+1, mem_we only in T+1, word becomes 0x1122AB44, resp_valid at T+2. SH 0xBEEF to 0x40002 -> 0xBEEFAB44.
- SW 0xDEADBEEF to 0x40010 then LW 0x40010 on the next cycle -> resp_valid in both following cycles, load returns 0xDEADBEEF.
- SB accepted, rst=1 during RMW_WR -> mem_we 0, word unchanged, no resp_valid, req_ready=1 the cycle after reset.
- LH 0x40001 over 0x11223344:
  - with LSU_MISALIGN_TRAP_EN: misalign=1, resp_rdata=0
  - without: resp_rdata=0x00003344, misalign=0
- SW 0x1 to 0x40006:
  - with LSU_MISALIGN_TRAP_EN: misalign=1, memory unchanged
  - without: word 0x10001 becomes 0x00000001
